// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS datapath: register widths,
// architectural register indices and the register-destination select encoding.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;
    localparam int MIPS_DEPTH  = 2 ** MIPS_ADDR_W;

    localparam logic [MIPS_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [MIPS_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [MIPS_ADDR_W-1:0] REG_RA   = 5'd31;

    localparam logic [MIPS_DATA_W-1:0] SP_RESET_DEFAULT = 32'd227;

    // Destination choices produced by the register-destination select stage.
    typedef enum logic [2:0] {
        RDST_RT = 3'd0,
        RDST_RD = 3'd1,
        RDST_RS = 3'd2,
        RDST_SP = 3'd3,
        RDST_RA = 3'd4
    } reg_dst_e;

    function automatic logic [MIPS_ADDR_W-1:0] sel_write_reg(
        input reg_dst_e                 sel,
        input logic [MIPS_ADDR_W-1:0]   rs,
        input logic [MIPS_ADDR_W-1:0]   rt,
        input logic [MIPS_ADDR_W-1:0]   rd
    );
        case (sel)
            RDST_RD: return rd;
            RDST_RS: return rs;
            RDST_SP: return REG_SP;
            RDST_RA: return REG_RA;
            default: return rt;
        endcase
    endfunction

endpackage

// File: rtl/reg_bank_rport.sv
// One combinational read port of reg_bank: forces index 0 to zero and, when
// REG_BANK_BYPASS_EN is defined, forwards same-cycle write data on an index match.
module reg_bank_rport
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int ADDR_W = MIPS_ADDR_W
) (
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic bypass_hit;

`ifdef REG_BANK_BYPASS_EN
    // wen_i already excludes reset and writes to index 0.
    assign bypass_hit = wen_i && (waddr_i == raddr_i);
`else
    logic unused_bypass;
    assign bypass_hit    = 1'b0;
    assign unused_bypass = ^{wen_i, waddr_i, wdata_i};
`endif

    always_comb begin
        if (raddr_i == '0) begin
            rdata_o = '0;
        end else if (bypass_hit) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = stored_i;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// 32-entry MIPS general-purpose register bank: two combinational read ports and one
// synchronous write port. Optional same-cycle write-through: REG_BANK_BYPASS_EN.
module reg_bank
    import mips_pkg::*;
#(
    parameter int                DATA_W   = MIPS_DATA_W,
    parameter int                ADDR_W   = MIPS_ADDR_W,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] bank_q [DEPTH];
    logic [DATA_W-1:0] bank_d [DEPTH];
    logic              wr_en;

    assign wr_en = RegWrite && reset && (WriteReg != '0);

    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no latch is inferred.
        bank_d = bank_q;
        if (wr_en) begin
            bank_d[WriteReg] = WriteData;
        end
    end

    // NOTE: the bank is built from flops, so every entry takes the async reset; a RAM macro could not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
            bank_q[ADDR_W'(REG_SP)] <= SP_RESET;
        end else begin
            bank_q <= bank_d;
        end
    end

    reg_bank_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport1 (
        .raddr_i  (ReadReg1),
        .stored_i (bank_q[ReadReg1]),
        .wen_i    (wr_en),
        .waddr_i  (WriteReg),
        .wdata_i  (WriteData),
        .rdata_o  (ReadData1)
    );

    reg_bank_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport2 (
        .raddr_i  (ReadReg2),
        .stored_i (bank_q[ReadReg2]),
        .wen_i    (wr_en),
        .waddr_i  (WriteReg),
        .wdata_i  (WriteData),
        .rdata_o  (ReadData2)
    );

endmodule
